// File: rtl/mul_i8_arbiter.sv
// Round-robin front end sharing one pipelined signed 8x8 multiplier.
// Requester tags ride a shift pipe matched to the multiplier latency.
module mul_i8_arbiter #(
  parameter int NREQ         = 4,
  parameter int LATENCY      = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [8*NREQ-1:0] i_req_a,
  input  logic [8*NREQ-1:0] i_req_b,
  output logic [NREQ-1:0]   o_resp_valid,
  output logic [15:0]       o_resp_res,
  output logic              o_mul_ena,
  output logic [7:0]        o_mul_a,
  output logic [7:0]        o_mul_b,
  input  logic [15:0]       i_mul_res,
  output logic              o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt [NREQ];
  tag_t          tag [LATENCY];
  tag_t          tail;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            gany;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = !i_rst && i_req_valid[k] &&
                (cnt[k] < CW'(MAX_INFLIGHT));
    end
  end

  // Scan from ptr upward with wrap; first eligible wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gany && elig[IW'(j)]) begin
        gany = 1'b1;
        gidx = IW'(j);
      end
    end
    if (gany) grant[gidx] = 1'b1;
  end

  assign o_req_ready = grant;
  assign o_mul_ena   = gany;
  assign o_mul_a     = gany ? i_req_a[8*gidx +: 8] : 8'h00;
  assign o_mul_b     = gany ? i_req_b[8*gidx +: 8] : 8'h00;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (gany) begin
      ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag[i] <= '0;
      end
    end else begin
      tag[0] <= '{vld: gany, idx: gidx};
      for (int i = 1; i < LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  assign tail = tag[LATENCY-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_resp_valid <= '0;
      o_resp_res   <= '0;
    end else begin
      o_resp_valid <= tail.vld ? (NREQ'(1) << tail.idx) : '0;
      if (tail.vld) o_resp_res <= i_mul_res;
    end
  end

  // Accept and response in the same cycle cancel out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NREQ; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        case ({grant[k], o_resp_valid[k]})
          2'b10:   cnt[k] <= cnt[k] + 1'b1;
          2'b01:   cnt[k] <= cnt[k] - 1'b1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  always_comb begin
    o_busy = |o_resp_valid;
    for (int i = 0; i < LATENCY; i++) begin
      o_busy = o_busy | tag[i].vld;
    end
  end

endmodule

// File: tb/tb_mul_i8_arbiter.sv
// Directed bench for mul_i8_arbiter with a 4-cycle multiplier model.
module tb_mul_i8_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  resp_valid;
  logic [15:0] resp_res;
  logic        mul_ena;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_res;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mul_i8_arbiter #(.NREQ(4), .LATENCY(4), .MAX_INFLIGHT(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_resp_valid(resp_valid), .o_resp_res(resp_res),
    .o_mul_ena(mul_ena), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_res(mul_res), .o_busy(busy)
  );

  logic signed [15:0] prod;
  logic [15:0] mp [4];
  assign prod = $signed(mul_a) * $signed(mul_b);
  always @(posedge clk) begin
    mp[0] <= mul_ena ? prod : 16'h0;
    for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
  end
  assign mul_res = mp[3];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    req_valid = '0;
    cyc();
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1;
    req_valid = 4'hF;
    req_a = 32'h11223344;
    req_b = 32'h55667788;
    #1;
    compared++; if (req_ready !== 4'h0) begin mismatched++; $display("FAIL rst_ready got %h want 0", req_ready); end
    compared++; if (mul_ena !== 1'b0) begin mismatched++; $display("FAIL rst_ena got %b want 0", mul_ena); end
    compared++; if (mul_a !== 8'h00) begin mismatched++; $display("FAIL rst_mul_a got %h want 00", mul_a); end
    cyc();
    req_valid = '0;
    #1;
    compared++; if (resp_valid !== 4'h0) begin mismatched++; $display("FAIL rst_resp_valid got %h want 0", resp_valid); end
    compared++; if (resp_res !== 16'h0) begin mismatched++; $display("FAIL rst_resp_res got %h want 0", resp_res); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %b want 0", busy); end
  endtask

  task automatic run_one(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
    for (int c = 0; c < 7; c++) begin
      cyc();
      rst = 1'b0;
      req_valid = (c == 0) ? 4'(1 << k) : 4'h0;
      req_a[8*k +: 8] = a;
      req_b[8*k +: 8] = b;
      #1;
      if (c == 0) begin
        compared++; if (req_ready !== 4'(1 << k)) begin mismatched++; $display("FAIL one_ready k=%0d got %h want %h", k, req_ready, 4'(1 << k)); end
        compared++; if (mul_ena !== 1'b1) begin mismatched++; $display("FAIL one_ena k=%0d got %b want 1", k, mul_ena); end
        compared++; if ({mul_a, mul_b} !== {a, b}) begin mismatched++; $display("FAIL one_ops k=%0d got %h want %h", k, {mul_a, mul_b}, {a, b}); end
      end
      if (c == 1) begin
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL one_busy1 k=%0d got %b want 1", k, busy); end
      end
      if (c == 5) begin
        compared++; if (resp_valid !== 4'(1 << k)) begin mismatched++; $display("FAIL one_resp k=%0d got %h want %h", k, resp_valid, 4'(1 << k)); end
        compared++; if (resp_res !== exp) begin mismatched++; $display("FAIL one_res k=%0d got %h want %h", k, resp_res, exp); end
      end
      if (c == 6) begin
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL one_busy_end k=%0d got %b want 0", k, busy); end
        compared++; if (resp_valid !== 4'h0) begin mismatched++; $display("FAIL one_resp_end k=%0d got %h want 0", k, resp_valid); end
      end
    end
  endtask

  task automatic test_single_and_corners();
    do_reset();
    run_one(0, 8'hFD, 8'h07, 16'hFFEB);
    run_one(1, 8'h80, 8'h80, 16'h4000);
    run_one(2, 8'h80, 8'h7F, 16'hC080);
    run_one(3, 8'h00, 8'hFF, 16'h0000);
  endtask

  task automatic test_fairness();
    logic [15:0] exp [4];
    logic [3:0] er;
    logic [3:0] ev;
    exp[0] = 16'h000F; exp[1] = 16'hFFEE; exp[2] = 16'hD8F0; exp[3] = 16'h3F01;
    do_reset();
    req_a = {8'h7F, 8'h64, 8'hFE, 8'h03};
    req_b = {8'h7F, 8'h9C, 8'h09, 8'h05};
    for (int c = 0; c < 20; c++) begin
      cyc();
      rst = 1'b0;
      req_valid = (c < 12) ? 4'hF : 4'h0;
      #1;
      er = (c < 12) ? 4'(1 << (c % 4)) : 4'h0;
      ev = (c >= 5 && c < 17) ? 4'(1 << ((c - 5) % 4)) : 4'h0;
      compared++; if (req_ready !== er) begin mismatched++; $display("FAIL fair_ready c=%0d got %h want %h", c, req_ready, er); end
      compared++; if (resp_valid !== ev) begin mismatched++; $display("FAIL fair_resp c=%0d got %h want %h", c, resp_valid, ev); end
      if (ev != 4'h0) begin
        compared++; if (resp_res !== exp[(c - 5) % 4]) begin mismatched++; $display("FAIL fair_res c=%0d got %h want %h", c, resp_res, exp[(c - 5) % 4]); end
      end
    end
  endtask

  task automatic test_inflight_cap();
    logic [3:0] er;
    logic [3:0] ev;
    do_reset();
    req_a[23:16] = 8'h05;
    req_b[23:16] = 8'hFC;
    for (int c = 0; c < 12; c++) begin
      cyc();
      rst = 1'b0;
      req_valid = (c < 8) ? 4'b0100 : 4'h0;
      #1;
      er = (c == 0 || c == 1 || c == 6 || c == 7) ? 4'b0100 : 4'h0;
      ev = (c == 5 || c == 6 || c == 11) ? 4'b0100 : 4'h0;
      compared++; if (req_ready !== er) begin mismatched++; $display("FAIL cap_ready c=%0d got %h want %h", c, req_ready, er); end
      compared++; if (resp_valid !== ev) begin mismatched++; $display("FAIL cap_resp c=%0d got %h want %h", c, resp_valid, ev); end
      if (ev != 4'h0) begin
        compared++; if (resp_res !== 16'hFFEC) begin mismatched++; $display("FAIL cap_res c=%0d got %h want ffec", c, resp_res); end
      end
    end
  endtask

  task automatic test_simul_inc_dec();
    logic [3:0] er;
    logic [3:0] ev;
    do_reset();
    req_a[15:8] = 8'h06;
    req_b[15:8] = 8'hF9;
    for (int c = 0; c < 13; c++) begin
      cyc();
      rst = 1'b0;
      req_valid = (c == 0 || (c >= 5 && c <= 8)) ? 4'b0010 : 4'h0;
      #1;
      er = (c == 0 || c == 5 || c == 6) ? 4'b0010 : 4'h0;
      ev = (c == 5 || c == 10 || c == 11) ? 4'b0010 : 4'h0;
      compared++; if (req_ready !== er) begin mismatched++; $display("FAIL simul_ready c=%0d got %h want %h", c, req_ready, er); end
      compared++; if (resp_valid !== ev) begin mismatched++; $display("FAIL simul_resp c=%0d got %h want %h", c, resp_valid, ev); end
      if (ev != 4'h0) begin
        compared++; if (resp_res !== 16'hFFD6) begin mismatched++; $display("FAIL simul_res c=%0d got %h want ffd6", c, resp_res); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] er;
    logic [3:0] ev;
    do_reset();
    req_a = {8'hFB, 8'h44, 8'h33, 8'h02};
    req_b = {8'hFA, 8'h55, 8'h66, 8'h03};
    for (int c = 0; c < 12; c++) begin
      cyc();
      rst = (c == 3);
      case (c)
        0, 1, 2: req_valid = 4'b0111;
        3:       req_valid = 4'hF;
        4:       req_valid = 4'b1001;
        5:       req_valid = 4'b1000;
        default: req_valid = 4'h0;
      endcase
      #1;
      case (c)
        0: er = 4'b0001;
        1: er = 4'b0010;
        2: er = 4'b0100;
        4: er = 4'b0001;
        5: er = 4'b1000;
        default: er = 4'h0;
      endcase
      ev = (c == 9) ? 4'b0001 : (c == 10) ? 4'b1000 : 4'h0;
      compared++; if (req_ready !== er) begin mismatched++; $display("FAIL midrst_ready c=%0d got %h want %h", c, req_ready, er); end
      if (c >= 4) begin
        compared++; if (resp_valid !== ev) begin mismatched++; $display("FAIL midrst_resp c=%0d got %h want %h", c, resp_valid, ev); end
      end
      if (c == 3) begin
        compared++; if (mul_ena !== 1'b0) begin mismatched++; $display("FAIL midrst_ena got %b want 0", mul_ena); end
      end
      if (c == 4) begin
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy got %b want 0", busy); end
      end
      if (c == 9) begin
        compared++; if (resp_res !== 16'h0006) begin mismatched++; $display("FAIL midrst_res0 got %h want 0006", resp_res); end
      end
      if (c == 10) begin
        compared++; if (resp_res !== 16'h001E) begin mismatched++; $display("FAIL midrst_res3 got %h want 001e", resp_res); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single_and_corners();
    test_fairness();
    test_inflight_cap();
    test_simul_inc_dec();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
